// File: rtl/egg_timer_ctrl.sv
// Egg timer controller. The user sets a BCD minutes:seconds value while
// idle, then counts it down at 1 Hz and raises an alarm for a fixed
// number of seconds when it reaches zero.
// Optional feature macro: EGG_TIMER_PAUSE_EN. When it is defined, stop
// during a countdown pauses it instead of clearing it.
module egg_timer_ctrl #(
  parameter int MAX_MIN    = 99,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk_5MHz,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       min_up,
  input  logic       sec_up,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    ALARM = 3'd3
  } state_t;

  localparam logic [3:0] MAX_T      = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O      = 4'(MAX_MIN % 10);
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t      st;
  logic        tick_q;
  logic [7:0]  alarm_cnt;
  logic        tick_edge;
  logic [15:0] cur_time;
  logic        time_zero;
  logic        time_one;
  logic        any_btn;

  assign tick_edge = tick_1hz & ~tick_q;
  assign cur_time  = {min_tens, min_ones, sec_tens, sec_ones};
  assign time_zero = (cur_time == 16'h0000);
  assign time_one  = (cur_time == 16'h0001);
  assign any_btn   = start_btn | stop_btn | min_up | sec_up;
  assign state     = st;

  // Seconds setting: 00..59 then back to 00, never carries into minutes.
  function automatic logic [7:0] sec_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd5 && o == 4'd9) sec_inc = 8'h00;
    else if (o == 4'd9)         sec_inc = {t + 4'd1, 4'd0};
    else                        sec_inc = {t, o + 4'd1};
  endfunction

  // Minutes setting: 00..MAX_MIN then back to 00.
  function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == MAX_T && o == MAX_O) min_inc = 8'h00;
    else if (o == 4'd9)           min_inc = {t + 4'd1, 4'd0};
    else                          min_inc = {t, o + 4'd1};
  endfunction

  // One-second BCD countdown with borrow through all four digits;
  // only called with a non-zero time.
  function automatic logic [15:0] time_dec(input logic [15:0] v);
    logic [3:0] mt, mo, s_t, s_o;
    {mt, mo, s_t, s_o} = v;
    if (s_o != 4'd0) begin
      s_o = s_o - 4'd1;
    end else begin
      s_o = 4'd9;
      if (s_t != 4'd0) begin
        s_t = s_t - 4'd1;
      end else begin
        s_t = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    time_dec = {mt, mo, s_t, s_o};
  endfunction

  // Control FSM with registered time digits and status outputs.
  always_ff @(posedge clk_5MHz or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      tick_q    <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      tick_q <= tick_1hz;
      case (st)
        IDLE: begin
          if (start_btn && !stop_btn && !time_zero) begin
            st      <= RUN;
            running <= 1'b1;
          end else begin
            if (sec_up) {sec_tens, sec_ones} <= sec_inc(sec_tens, sec_ones);
            if (min_up) {min_tens, min_ones} <= min_inc(min_tens, min_ones);
          end
        end
        RUN: begin
          if (stop_btn) begin
            running <= 1'b0;
`ifdef EGG_TIMER_PAUSE_EN
            st      <= PAUSE;
`else
            st      <= IDLE;
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
`endif
          end else if (tick_edge) begin
            if (time_one) begin
              {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
              st        <= ALARM;
              running   <= 1'b0;
              alarm     <= 1'b1;
              alarm_cnt <= 8'd0;
            end else begin
              {min_tens, min_ones, sec_tens, sec_ones} <= time_dec(cur_time);
            end
          end
        end
`ifdef EGG_TIMER_PAUSE_EN
        PAUSE: begin
          if (stop_btn) begin
            st <= IDLE;
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
          end else if (start_btn) begin
            st      <= RUN;
            running <= 1'b1;
          end
        end
`endif
        ALARM: begin
          if (any_btn || (tick_edge && alarm_cnt == ALARM_LAST)) begin
            st        <= IDLE;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
          end else if (tick_edge) begin
            alarm_cnt <= alarm_cnt + 8'd1;
          end
        end
        default: begin
          st        <= IDLE;
          running   <= 1'b0;
          alarm     <= 1'b0;
          alarm_cnt <= 8'd0;
          {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with default parameters
// (MAX_MIN=99, ALARM_SECS=10). Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period from the
// active rising edge.
module tb_egg_timer_ctrl;

  logic       clk_5MHz = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       min_up = 1'b0;
  logic       sec_up = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  egg_timer_ctrl dut (
    .clk_5MHz (clk_5MHz),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .start_btn(start_btn),
    .stop_btn (stop_btn),
    .min_up   (min_up),
    .sec_up   (sec_up),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .alarm    (alarm),
    .state    (state)
  );

  always #100 clk_5MHz = ~clk_5MHz;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int tm();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  task automatic step();
    @(negedge clk_5MHz);
  endtask

  task automatic tick();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start(); start_btn = 1'b1; step(); start_btn = 1'b0; endtask
  task automatic press_stop();  stop_btn  = 1'b1; step(); stop_btn  = 1'b0; endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin sec_up = 1'b1; step(); sec_up = 1'b0; end
  endtask

  task automatic mins(input int n);
    for (int i = 0; i < n; i++) begin min_up = 1'b1; step(); min_up = 1'b0; end
  endtask

  initial begin
    // Reset state
    step(); step();
    check("rst_state", state, 0);
    check("rst_time", tm(), 'h0000);
    check("rst_running", running, 0);
    check("rst_alarm", alarm, 0);
    reset = 1'b0;
    step();

    // First tick after reset does nothing in IDLE
    tick();
    check("post_rst_tick_time", tm(), 'h0000);
    check("post_rst_tick_state", state, 0);

    // Set 01:03 and start
    secs(3); mins(1);
    check("set_0103", tm(), 'h0103);
    check("set_state_idle", state, 0);
    press_start();
    check("start_state", state, 1);
    check("start_running", running, 1);

    // Count down through the minute borrow
    ticks(3);
    check("run_0100", tm(), 'h0100);
    tick();
    check("run_0059", tm(), 'h0059);
    ticks(58);
    check("run_0001", tm(), 'h0001);
    tick();
    check("expire_time", tm(), 'h0000);
    check("expire_state", state, 3);
    check("expire_alarm", alarm, 1);
    check("expire_running", running, 0);

    // Alarm lasts ten tick edges
    ticks(9);
    check("alarm_9_state", state, 3);
    tick();
    check("alarm_10_state", state, 0);
    check("alarm_10_alarm", alarm, 0);

    // Alarm cleared early by stop
    secs(2); press_start(); ticks(2);
    check("rerun_alarm_state", state, 3);
    ticks(2);
    check("rerun_alarm_hold", state, 3);
    press_stop();
    check("stop_clears_alarm", state, 0);
    check("stop_clears_alarm_out", alarm, 0);

    // Alarm cleared by min_up, which does not change the time
    secs(1); press_start(); tick();
    check("alarm3_state", state, 3);
    mins(1);
    check("minup_clears_alarm", state, 0);
    check("minup_no_set", tm(), 'h0000);

    // Setting wrap-around and start at zero
    secs(59);
    check("sec_59", tm(), 'h0059);
    secs(1);
    check("sec_wrap", tm(), 'h0000);
    mins(99);
    check("min_99", tm(), 'h9900);
    mins(1);
    check("min_wrap", tm(), 'h0000);
    press_start();
    check("start_at_zero", state, 0);

    // BCD borrow across minute tens, min_up ignored while running
    mins(10); press_start();
    mins(1);
    check("run_ignore_minup", tm(), 'h1000);
    tick();
    check("run_0959", tm(), 'h0959);
    press_stop();
`ifdef EGG_TIMER_PAUSE_EN
    press_stop();
`endif
    check("stop_to_idle_state", state, 0);
    check("stop_to_idle_time", tm(), 'h0000);

    // Stop coincident with a tick edge at 00:05
    secs(5); press_start();
    stop_btn = 1'b1; tick_1hz = 1'b1; step();
    stop_btn = 1'b0; tick_1hz = 1'b0;
`ifdef EGG_TIMER_PAUSE_EN
    check("pause_state", state, 2);
    check("pause_time", tm(), 'h0005);
    check("pause_running", running, 0);
    step();
    press_start();
    check("resume_state", state, 1);
    check("resume_time", tm(), 'h0005);
    press_stop(); press_stop();
`else
    check("stop_tick_state", state, 0);
    check("stop_tick_time", tm(), 'h0000);
`endif
    step();

    // Start and stop together: stop wins
    secs(1);
    start_btn = 1'b1; stop_btn = 1'b1; step();
    start_btn = 1'b0; stop_btn = 1'b0;
    check("start_stop_idle", state, 0);
    secs(59);

    // Asynchronous reset during RUN at 02:30
    mins(2); secs(30);
    check("set_0230", tm(), 'h0230);
    press_start();
    check("run_0230", state, 1);
    #30 reset = 1'b1;
    #10;
    check("async_state", state, 0);
    check("async_time", tm(), 'h0000);
    check("async_running", running, 0);
    check("async_alarm", alarm, 0);
    #10 reset = 1'b0;
    step();
    press_start();
    check("after_rst_start", state, 0);
    check("after_rst_time", tm(), 'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 99, giving the highest settable minute value (BCD, 1..99).
REQ-002 The block SHALL have parameter ALARM_SECS, default 10, giving the alarm duration in 1 Hz ticks (1..255).
REQ-003 Port clk_5MHz  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port tick_1hz  input  1  1 Hz square wave from the divider, synchronous to clk_5MHz; each rising edge is one second.
REQ-006 Port start_btn  input  1  single-cycle, debounced start/resume pulse.
REQ-007 Port stop_btn  input  1  single-cycle, debounced stop/pause/clear pulse.
REQ-008 Port min_up  input  1  single-cycle pulse that increments the minutes setting.
REQ-009 Port sec_up  input  1  single-cycle pulse that increments the seconds setting.
REQ-010 Ports min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD time digits for the display scanner.
REQ-011 Port running  output  1  high only in the RUN state.
REQ-012 Port alarm  output  1  high only in the ALARM state.
REQ-013 Port state  output  3  encoding IDLE=0, RUN=1, PAUSE=2, ALARM=3; codes 4..7 are unused.

Function
REQ-014 The block SHALL register tick_1hz into tick_q and define tick_edge = tick_1hz & ~tick_q; all second-counting uses tick_edge only.
REQ-015 In IDLE, sec_up SHALL increment seconds 00->59, then wrap to 00 with no carry into minutes.
REQ-016 In IDLE, min_up SHALL increment minutes 00->MAX_MIN, then wrap to 00; min_up and sec_up in the same cycle both apply.
REQ-017 In IDLE, start_btn with a non-zero time SHALL enter RUN at the next edge; with time 00:00 it SHALL be ignored.
REQ-018 In RUN, each tick_edge SHALL decrement the time by one second, registered at that edge; ss=00 with mm>0 gives (mm-1):59, with BCD borrow across the digits.
REQ-019 In RUN, a tick_edge at 00:01 SHALL produce 00:00 and enter ALARM at the same edge.
REQ-020 In RUN, stop_btn SHALL take priority over a coincident tick_edge; no decrement occurs in that cycle.
REQ-021 In ALARM, the time SHALL hold at 00:00 and an 8-bit counter SHALL count tick_edges.
REQ-022 After ALARM_SECS tick_edges, or on any of start_btn, stop_btn, min_up or sec_up, the block SHALL return from ALARM to IDLE.
REQ-023 In RUN, PAUSE and ALARM, min_up and sec_up SHALL be ignored, except that they clear ALARM as stated in REQ-022.
REQ-024 If start_btn and stop_btn occur in the same cycle, stop_btn SHALL win in every state.
REQ-025 Unused state codes SHALL transition to IDLE at the next edge with the time cleared to 00:00.

Reset
REQ-026 Reset SHALL force state=IDLE, all digits=0, running=0, alarm=0, tick_q=0 and the alarm counter=0, independent of the clock.
REQ-027 Reset asserted mid-RUN or mid-ALARM SHALL abandon the countdown with no retained time.
REQ-028 After reset deasserts, the first tick_edge SHALL have no effect, because the block is in IDLE.

Configuration
REQ-029 Macro EGG_TIMER_PAUSE_EN SHALL gate the pause feature.
- Defined: stop_btn in RUN enters PAUSE with the time held; start_btn in PAUSE resumes RUN; stop_btn in PAUSE enters IDLE and clears the time to 00:00.
- Undefined: stop_btn in RUN enters IDLE and clears the time to 00:00; the PAUSE state is never entered, and code 2 is treated as unused per REQ-025.

Verification
REQ-030 Reset, then 3x sec_up and 1x min_up -> digits 0,1,0,3 in IDLE; start_btn -> state=1 and running=1 at the next edge.
REQ-031 Time 01:00 in RUN, one tick_edge -> 00:59; from 00:01, one tick_edge -> 00:00, state=3, alarm=1 at the same edge.
REQ-032 ALARM with ALARM_SECS=10: 10 tick_edges -> state=0, alarm=0; a repeat run with stop_btn after 2 tick_edges -> state=0 immediately.
REQ-033 60x sec_up from 00:00 -> 00:00; 100x min_up -> 00:xx; start_btn at 00:00 -> state stays 0.
REQ-034 RUN at 00:05, stop_btn coincident with tick_edge -> macro defined: PAUSE at 00:05, then start_btn -> RUN with 00:05 unchanged; macro undefined: IDLE at 00:00.
REQ-035 Async reset pulse between clock edges during RUN at 02:30 -> all outputs 0 before the next clock edge; start_btn afterwards is ignored (time 00:00).
